// File: rtl/spi_master_pkg.sv
// Shared types and defaults for the SPI word reader.
// The master drives the bus in mode 1: SCK idles low, the slave shifts on rising SCK and the master samples on falling SCK.
package spi_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        HOLD,
        GAP
    } spi_mst_state_t;

    localparam int DEF_WIDTH        = 32;
    localparam int DEF_CLK_DIV      = 4;
    localparam int DEF_CS_SETUP_CYC = 2;
    localparam int DEF_CS_HOLD_CYC  = 2;
    localparam int DEF_IDLE_GAP_CYC = 4;

    // {CPOL, CPHA}: bit 1 is the idle level of SCK, bit 0 set means data is sampled on the trailing edge
    localparam logic [1:0] SPI_MODE = 2'b01;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spi_master_reader.sv
// SPI master that clocks one WIDTH-bit word out of the slave per start request,
// shifting tx_data out on MOSI at the same time.
module spi_master_reader
    import spi_master_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int CS_SETUP_CYC = DEF_CS_SETUP_CYC,
    parameter int CS_HOLD_CYC  = DEF_CS_HOLD_CYC,
    parameter int IDLE_GAP_CYC = DEF_IDLE_GAP_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             SPI_Clk,
    output logic             SPI_CS_n,
    output logic             SPI_MOSI,
    input  logic             SPI_MISO
);

    localparam int BIT_W   = $clog2(WIDTH + 1);
    localparam int CNT_MAX = max_of4(CLK_DIV, CS_SETUP_CYC, CS_HOLD_CYC, IDLE_GAP_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(IDLE_GAP_CYC - 1);
    localparam logic             SCK_IDLE   = SPI_MODE[1];

    spi_mst_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             sck_q, sck_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;

    logic             miso_sync;
    logic             state_done;
    logic             fall_cycle;
    logic             accept;

    sync_2ff u_miso_sync (
        .clk   (clk),
        .reset (reset),
        .d     (SPI_MISO),
        .q     (miso_sync)
    );

    // Every timed state reloads the counter on entry and leaves when it reaches zero.
    assign state_done = (cnt_q == '0);
    assign fall_cycle = (state_q == SCK_LO) && (cnt_q == DIV_LOAD);
    assign accept     = (state_q == IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sck_q      <= SCK_IDLE;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)      state_d = SETUP;
            SETUP:   if (state_done) state_d = SCK_HI;
            SCK_HI:  if (state_done) state_d = SCK_LO;
            SCK_LO:  if (state_done) state_d = (bit_cnt_q != '0) ? SCK_HI : HOLD;
            HOLD:    if (state_done) state_d = GAP;
            GAP:     if (state_done) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        if (state_d != state_q) begin
            unique case (state_d)
                SETUP:          cnt_d = SETUP_LOAD;
                SCK_HI, SCK_LO: cnt_d = DIV_LOAD;
                HOLD:           cnt_d = HOLD_LOAD;
                GAP:            cnt_d = GAP_LOAD;
                default:        cnt_d = '0;
            endcase
        end else if (!state_done) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (accept) begin
            tx_shift_d = tx_data;
            bit_cnt_d  = BIT_W'(WIDTH);
        end

        // The synchronizer delay is two cycles, so with CLK_DIV >= 3 this already sees the bit launched on the last rising SCK.
        if (fall_cycle) begin
            rx_shift_d = {rx_shift_q[WIDTH-2:0], miso_sync};
            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
            bit_cnt_d  = bit_cnt_q - BIT_W'(1);
        end

        if ((state_q == HOLD) && state_done) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end
    end

    // Bus pins are registered from the upcoming state so they change on the same edge as the state.
    always_comb begin
        cs_n_d = (state_d == IDLE) || (state_d == GAP);
        sck_d  = (state_d == SCK_HI) ? ~SCK_IDLE : SCK_IDLE;
        mosi_d = cs_n_d ? 1'b0 : tx_shift_d[WIDTH-1];
    end

    assign busy     = (state_q != IDLE);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign SPI_Clk  = sck_q;
    assign SPI_CS_n = cs_n_q;
    assign SPI_MOSI = mosi_q;

endmodule

// File: doc/spi_master_reader.md
# spi_master_reader

SPI master that reads one 32-bit word from the counter SPI slave per transaction. It sits in the FPGA fabric on the system clock, generates `SPI_Clk` and `SPI_CS_n`, and shifts out an optional command word on `SPI_MOSI`. It returns the received word to local logic with a single-cycle valid strobe. Bus mode: `SPI_Clk` idles low, MSb first; the slave changes `SPI_MISO` on rising `SPI_Clk`, the master samples on falling `SPI_Clk`.

## Interface
Parameters:
- `WIDTH`, 32: word length in bits (transaction length).
- `CLK_DIV`, 4: `SPI_Clk` half-period in `clk` cycles; must be ≥3.
- `CS_SETUP_CYC`, 2: cycles from `SPI_CS_n` low to the first rising `SPI_Clk`; ≥1.
- `CS_HOLD_CYC`, 2: cycles from the last falling `SPI_Clk` to `SPI_CS_n` high; ≥1.
- `IDLE_GAP_CYC`, 4: minimum `SPI_CS_n` high time between transactions; ≥1.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: reset, asynchronous, active-low.
- `start` in 1: request a transaction; accepted only when `busy`=0.
- `tx_data` in WIDTH: word shifted out on MOSI; captured when `start` is accepted.
- `busy` out 1: high from the acceptance cycle through the end of the idle gap.
- `rx_data` out WIDTH: last received word; holds its value until the next `rx_valid`.
- `rx_valid` out 1: one-cycle pulse when `rx_data` updates.
- `SPI_Clk` out 1: serial clock, registered.
- `SPI_CS_n` out 1: chip select, active-low, registered.
- `SPI_MOSI` out 1: serial data out, registered.
- `SPI_MISO` in 1: serial data in; asynchronous to `clk`, so it is synchronized.

## Operation
- States: IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP.
- **IDLE**
  - Outputs: `SPI_CS_n`=1, `SPI_Clk`=0, `busy`=0.
  - `start`=1 → capture `tx_data` into the shift register, set bit counter = WIDTH, go to SETUP.
- **SETUP**
  - Outputs: `SPI_CS_n`=0, `SPI_MOSI`=tx MSb.
  - After CS_SETUP_CYC cycles → SCK_HI.
- **SCK_HI**
  - Output: `SPI_Clk`=1 for CLK_DIV cycles.
  - → SCK_LO.
- **SCK_LO**
  - In the first cycle (the falling-edge cycle): shift synchronized MISO into the rx shift register LSb, decrement the bit counter, shift MOSI to the next bit.
  - After CLK_DIV cycles: bit counter ≠0 → SCK_HI, else → HOLD.
- **HOLD**
  - `SPI_CS_n` stays 0 for CS_HOLD_CYC cycles.
  - Then set `SPI_CS_n`=1, load `rx_data`, pulse `rx_valid`, go to GAP.
- **GAP**
  - `SPI_CS_n`=1, `busy`=1 for IDLE_GAP_CYC cycles.
  - → IDLE.
- MISO passes through a 2-flop synchronizer. CLK_DIV≥3 guarantees the sampled value follows the preceding rising edge.
- `SPI_MOSI` is 0 whenever `SPI_CS_n`=1.
- `start` while `busy`=1 is ignored; it is neither queued nor captured.
- `start` held high continuously → back-to-back transactions separated by exactly IDLE_GAP_CYC cycles plus one IDLE cycle.
- Bit counter is 6 bits for WIDTH=32, in general $clog2(WIDTH+1). Divider counter is $clog2(max(CLK_DIV, CS_SETUP_CYC, CS_HOLD_CYC, IDLE_GAP_CYC)) bits. No wrap: every counter reloads on each state entry.
- Reset (asynchronous, any state) forces:
  - state IDLE;
  - `SPI_CS_n`=1, `SPI_Clk`=0, `SPI_MOSI`=0;
  - `busy`=0, `rx_valid`=0, `rx_data`=0.
  
  An interrupted transaction produces no `rx_valid`.

## Timing
- Start accepted at cycle 0 (S=CS_SETUP_CYC, D=CLK_DIV, H=CS_HOLD_CYC, G=IDLE_GAP_CYC).
- `SPI_CS_n` falls at cycle 1 and `busy` rises at cycle 1.
- First rising `SPI_Clk` at cycle 1+S; rising edge k (0-based) at 1+S+2kD; falling edge k at 1+S+(2k+1)D.
- Last falling edge at 1+S+(2·WIDTH−1)D.
- `SPI_CS_n` rises and `rx_valid` pulses at cycle 1+S+2·WIDTH·D+H. Defaults: cycle 261.
- `busy` falls at cycle 1+S+2·WIDTH·D+H+G. Defaults: 265. Next `start` is accepted that cycle.
- `rx_data` is stable from the `rx_valid` cycle onward.

## Structure
- Package `spi_master_pkg`:
  - state enum `spi_mst_state_t`;
  - default parameter constants;
  - the SPI mode constant (CPOL=0, sample on falling edge).
- Sub-module `sync_2ff`: 1-bit, async active-low reset to 0, used for `SPI_MISO`.
- Everything else is in the single module.

## Test plan
- Behavioral slave (loads on CS fall, updates MISO on rising SCK, preloads MSb) holding 0xDEADBEEF, one `start` → `rx_data`=0xDEADBEEF, `rx_valid` high exactly at cycle 261, one cycle wide.
- `tx_data`=0xA5A50F0F → bits captured at each rising `SPI_Clk` equal 0xA5A50F0F MSb first; MOSI=0 outside CS; exactly 32 rising edges per CS window.
- `start` pulsed at cycles 10 and 100 of a transaction → ignored; a single transaction only.
- `start` held high, slave words 0x00000000 then 0xFFFFFFFF → two `rx_valid` pulses with those values; CS high for exactly IDLE_GAP_CYC+1 cycles between them.
- Reset asserted mid-shift (after bit 12) → same-cycle (asynchronous) CS_n=1, SCK=0, busy=0, `rx_data`=0, no `rx_valid`; a following `start` reads the full word correctly.
- CLK_DIV=3 with MISO changing 1 ns after rising SCK, slave word 0x12345678 → `rx_data`=0x12345678.
